sm_muldiv: RTL

- Parametrised iterative multiply/divide unit for the schoolMIPS datapath; successor to the single-cycle ALU, adding multi-cycle MULT/MULTU/DIV/DIVU with HI/LO result registers.
- Sits beside the ALU. The control unit issues a one-cycle start; the CPU stalls on busy; results are read via MFHI/MFLO and written via MTHI/MTLO.
- Radix-2, one bit per cycle, operand width set by parameter.

---
 rtl/sm_muldiv_pkg.sv | 41 ++++
 rtl/sm_muldiv_step.sv | 44 ++++
 rtl/sm_muldiv.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sm_muldiv_pkg.sv
// Shared definitions for the schoolMIPS multiply/divide unit and the control
// unit that drives it: operation codes, FSM state codes and the R-type funct
// values of the HI/LO instructions.
package sm_muldiv_pkg;

    // Operation select driven by sm_control; bit 1 = divide, bit 0 = signed
    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    // Iterative unit state
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    // R-type funct field values decoded by sm_control
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    // True for DIV/DIVU
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // True for MULT/DIV (two's-complement operands)
    function automatic logic md_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/sm_muldiv_step.sv
// One radix-2 iteration of the multiply/divide unit, purely combinational.
// The 2*WIDTH accumulator is shared by both operations:
//   multiply: {partial product high, remaining multiplier bits}, shifts right
//   divide:   {partial remainder, dividend bits / quotient bits}, shifts left
module sm_muldiv_step
#(
    parameter int WIDTH = 32
)
(
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_tmp;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_new;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [2*WIDTH-1:0] w_div_acc;

    // Shift-add (multiply) and restoring shift-subtract (divide) side by side
    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is set,
        // then shift right; the carry drops into the top accumulator bit.
        w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (i_acc[0] ? i_opnd : {WIDTH{1'b0}})};
        w_mul_acc = {w_sum, i_acc[WIDTH-1:1]};

        // Divide: bring the next dividend bit into the remainder and try to
        // subtract. The remainder is always below the divisor, so whichever
        // value is kept fits in WIDTH bits and the truncated difference is exact.
        w_tmp     = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_ge      = (w_tmp >= {1'b0, i_opnd});
        w_diff    = w_tmp[WIDTH-1:0] - i_opnd;
        w_rem_new = w_ge ? w_diff : w_tmp[WIDTH-1:0];
        w_div_acc = {w_rem_new, i_acc[WIDTH-2:0], w_ge};

        o_acc     = i_is_div ? w_div_acc : w_mul_acc;
    end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative multiply/divide unit for the schoolMIPS datapath with HI/LO
// registers. One bit per cycle: start -> WIDTH CALC cycles -> one FIX cycle
// for sign correction -> done pulse with the new HI/LO.
module sm_muldiv
    import sm_muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    md_state_e          r_state;
    md_state_e          w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_neg_res;   // product / quotient must be negated
    logic               r_neg_rem;   // remainder takes a negative dividend's sign
    logic               r_b_zero;    // divisor was zero
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_busy;
    logic               w_accept;
    logic               w_calc;
    logic               w_fix;
    logic               w_mt_ok;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    sm_muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_acc_step)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: IDLE -> CALC on start, CALC for WIDTH cycles, one FIX cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MD_IDLE: if (start)            w_state_next = MD_CALC;
            MD_CALC: if (r_cnt == CNT_LAST) w_state_next = MD_FIX;
            MD_FIX:                         w_state_next = MD_IDLE;
            default:                        w_state_next = MD_IDLE;
        endcase
    end

    // FSM outputs: a start in IDLE takes priority over MTHI/MTLO
    always_comb begin
        w_busy   = (r_state != MD_IDLE);
        w_accept = (r_state == MD_IDLE) && start;
        w_calc   = (r_state == MD_CALC);
        w_fix    = (r_state == MD_FIX);
        w_mt_ok  = (r_state == MD_IDLE) && !start;
    end

    // Operand magnitudes for signed operations
    always_comb begin
        w_signed = md_is_signed(op);
        w_a_neg  = w_signed && srcA[WIDTH-1];
        w_b_neg  = w_signed && srcB[WIDTH-1];
        w_mag_a  = w_a_neg ? -srcA : srcA;
        w_mag_b  = w_b_neg ? -srcB : srcB;
    end

    // Operand latch on accept, then one iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= CNT_INIT;
            r_is_div  <= md_is_div(op);
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_b_zero  <= (srcB == '0);
            if (md_is_div(op)) begin
                // dividend enters the low half, divisor is the step operand
                r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
                r_opnd <= w_mag_b;
            end else begin
                // multiplier enters the low half, multiplicand is the step operand
                r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
                r_opnd <= w_mag_a;
            end
        end else if (w_calc) begin
            r_cnt <= r_cnt - 1'b1;
            r_acc <= w_acc_step;
        end
    end

    // Sign fix-up of the unsigned result. A zero divisor yields an all-ones
    // quotient; the remainder path already reproduces the dividend in that case.
    always_comb begin
        w_prod = r_neg_res ? -r_acc : r_acc;
        w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        if (r_is_div) begin
            w_res_hi = w_rem;
            w_res_lo = r_b_zero ? {WIDTH{1'b1}} : w_quot;
        end else begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end
    end

    // HI/LO: result at the FIX edge, MTHI/MTLO only when idle and not starting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fix) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (w_mt_ok) begin
            if (hiWe) r_hi <= wd;
            if (loWe) r_lo <= wd;
        end
    end

    // One-cycle completion pulse following the FIX cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix;
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
